// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared opcodes, NOP encoding and fetch FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

  localparam logic [5:0]  OPC_JUMP  = 6'b000100;
  localparam logic [5:0]  OPC_BEQ   = 6'b000011;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/ifid_register.sv
// ============================================================================
// Module      : ifid_register
// Description : IF/ID pipeline register with hold (stall) and flush controls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifid_register
  import core_pkg::*;
#(
  parameter int P_SIZE = 32,
  parameter int I_SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic [I_SIZE-1:0] d_instr,
  input  logic [P_SIZE-1:0] d_pc,
  input  logic              d_valid,
  output logic [I_SIZE-1:0] q_instr,
  output logic [P_SIZE-1:0] q_pc,
  output logic              q_valid
);

  logic [I_SIZE-1:0] r_instr;
  logic [P_SIZE-1:0] r_pc;
  logic              r_valid;

  // Flush outranks hold so a redirect can clear a stalled slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= I_SIZE'(NOP_INSTR);
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_instr <= I_SIZE'(NOP_INSTR);
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (!hold) begin
      r_instr <= d_instr;
      r_pc    <= d_pc;
      r_valid <= d_valid;
    end
  end

  assign q_instr = r_instr;
  assign q_pc    = r_pc;
  assign q_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Fetch stage: PC ownership, zero-penalty jumps, redirect/stall
//               handling and halt on out-of-range fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit
  import core_pkg::*;
#(
  parameter int P_SIZE = 32,
  parameter int I_SIZE = 32,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_stall,
  input  logic              ex_redirect,
  input  logic [P_SIZE-1:0] ex_target,
  input  logic [I_SIZE-1:0] im_Instruction,
  output logic [P_SIZE-1:0] pc,
  output logic [I_SIZE-1:0] ifid_instr,
  output logic [P_SIZE-1:0] ifid_pc,
  output logic              ifid_valid,
  output logic              fetch_fault,
  output logic [31:0]       fetch_count
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic [P_SIZE-1:0] r_pc;
  logic [P_SIZE-1:0] w_pc_next;
  logic              r_fault;
  logic [31:0]       r_count;

  logic              w_flush;
  logic              w_hold;
  logic              w_set_fault;
  logic              w_deliver;
  logic              w_pc_ok;
  logic              w_tgt_ok;
  logic              w_is_jump;
  logic [P_SIZE-1:0] w_jump_pc;

  assign w_pc_ok   = (r_pc < P_SIZE'(DEPTH));
  assign w_tgt_ok  = (ex_target < P_SIZE'(DEPTH));
  assign w_is_jump = (im_Instruction[31:26] == OPC_JUMP);
  assign w_jump_pc = r_pc + P_SIZE'(im_Instruction[25:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_next;
  end

  // Priority in RUN: redirect > fault > stall > jump > sequential.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_flush      = 1'b0;
    w_hold       = 1'b0;
    w_set_fault  = 1'b0;
    case (r_state)
      RUN: begin
        if (ex_redirect) begin
          w_pc_next = ex_target;
          w_flush   = 1'b1;
        end else if (!w_pc_ok) begin
          w_state_next = HALT;
          w_set_fault  = 1'b1;
          w_flush      = 1'b1;
        end else if (if_stall) begin
          w_hold = 1'b1;
        end else if (w_is_jump) begin
          w_pc_next = w_jump_pc;
        end else begin
          w_pc_next = r_pc + P_SIZE'(1);
        end
      end
      HALT: begin
        w_flush = 1'b1;
        if (ex_redirect && w_tgt_ok) begin
          w_pc_next    = ex_target;
          w_state_next = RUN;
        end
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

  assign w_deliver = !w_flush && !w_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= '0;
      r_fault <= 1'b0;
      r_count <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (w_set_fault) r_fault <= 1'b1;
      if (w_deliver && (r_count != 32'hFFFF_FFFF)) r_count <= r_count + 32'd1;
    end
  end

  ifid_register #(
    .P_SIZE (P_SIZE),
    .I_SIZE (I_SIZE)
  ) u_ifid (
    .clk     (clk),
    .rst     (rst),
    .hold    (w_hold),
    .flush   (w_flush),
    .d_instr (im_Instruction),
    .d_pc    (r_pc),
    .d_valid (1'b1),
    .q_instr (ifid_instr),
    .q_pc    (ifid_pc),
    .q_valid (ifid_valid)
  );

  assign pc          = r_pc;
  assign fetch_fault = r_fault;
  assign fetch_count = r_count;

endmodule

`default_nettype wire
